extend_pipe: RTL and testbench

EXTEND_PIPE -- requirements
Module: extend_pipe

---
 rtl/extend_pipe.sv | 129 ++++++++++++
 tb/tb_extend_pipe.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/extend_pipe.sv
// extend_pipe
//   Immediate / load-data extension stage with a two-entry elastic buffer.
//   The offered word is extended combinationally according to in_mode and
//   captured into the main register M, which drives the outputs. A skid
//   register S absorbs one extra word when M is stalled, so that in_ready
//   can come straight from a flop with no path from out_ready.
//
// Ports
//   clock      rising-edge clock for all state
//   reset      synchronous, active-high reset
//   flush      empties both entries and drops this cycle's input
//   in_valid   input word offered
//   in_ready   input word can be accepted this cycle (= S is empty)
//   in_mode    extension mode (0 SEXT, 1 ZEXT, 2 LUI, 3 SEXT_B, 4 ZEXT_B,
//              5 BRANCH, other codes reserved)
//   in_data    raw immediate / load data
//   out_valid  result held on the output
//   out_ready  downstream takes the result this cycle
//   out_data   extended result
//   out_err    result came from a reserved mode
module extend_pipe #(
  parameter int NB_DATA = 32,
  parameter int NB_WORD = 16,
  parameter int NB_MODE = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NB_MODE-1:0] in_mode,
  input  logic [NB_WORD-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NB_DATA-1:0] out_data,
  output logic               out_err
);

  localparam logic [NB_MODE-1:0] MODE_SEXT   = NB_MODE'(0);
  localparam logic [NB_MODE-1:0] MODE_ZEXT   = NB_MODE'(1);
  localparam logic [NB_MODE-1:0] MODE_LUI    = NB_MODE'(2);
  localparam logic [NB_MODE-1:0] MODE_SEXT_B = NB_MODE'(3);
  localparam logic [NB_MODE-1:0] MODE_ZEXT_B = NB_MODE'(4);
  localparam logic [NB_MODE-1:0] MODE_BRANCH = NB_MODE'(5);

  localparam int NB_PAD = NB_DATA - NB_WORD;

  logic [NB_DATA-1:0] sext_word;
  logic [NB_DATA-1:0] ext_data;
  logic               ext_err;

  logic               m_valid;
  logic [NB_DATA-1:0] m_data;
  logic               m_err;

  logic               s_valid;
  logic [NB_DATA-1:0] s_data;
  logic               s_err;

  logic               accept;
  logic               out_xfer;

  // The branch offset reuses the full-width sign extension, then drops the
  // top two bits to make room for the word-alignment shift.
  assign sext_word = {{NB_PAD{in_data[NB_WORD-1]}}, in_data};

  always_comb begin
    ext_data = '0;
    ext_err  = 1'b0;
    case (in_mode)
      MODE_SEXT:   ext_data = sext_word;
      MODE_ZEXT:   ext_data = {{NB_PAD{1'b0}}, in_data};
      MODE_LUI:    ext_data = {in_data, {NB_PAD{1'b0}}};
      MODE_SEXT_B: ext_data = {{(NB_DATA-8){in_data[7]}}, in_data[7:0]};
      MODE_ZEXT_B: ext_data = {{(NB_DATA-8){1'b0}}, in_data[7:0]};
      MODE_BRANCH: ext_data = {sext_word[NB_DATA-3:0], 2'b00};
      default: begin
        ext_data = '0;
        ext_err  = 1'b1;
      end
    endcase
  end

  assign in_ready  = ~s_valid;
  assign accept    = in_valid & in_ready;
  assign out_xfer  = m_valid & out_ready;

  assign out_valid = m_valid;
  assign out_data  = m_data;
  assign out_err   = m_err;

  // M advances only when it is empty or being consumed, which keeps the
  // output stable under backpressure. S is filled only when M is stalled;
  // since in_ready is low whenever S is full, an input can never arrive in
  // the same cycle that S drains into M.
  always_ff @(posedge clock) begin
    if (reset) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_err   <= 1'b0;
      s_valid <= 1'b0;
      s_data  <= '0;
      s_err   <= 1'b0;
    end else if (flush) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
    end else begin
      if (!m_valid || out_xfer) begin
        if (s_valid) begin
          m_valid <= 1'b1;
          m_data  <= s_data;
          m_err   <= s_err;
          s_valid <= 1'b0;
        end else begin
          m_valid <= accept;
          if (accept) begin
            m_data <= ext_data;
            m_err  <= ext_err;
          end
        end
      end else if (accept) begin
        s_valid <= 1'b1;
        s_data  <= ext_data;
        s_err   <= ext_err;
      end
    end
  end

endmodule

// File: tb/tb_extend_pipe.sv
// tb_extend_pipe
//   Directed bench for extend_pipe. Stimulus tasks push the hand-computed
//   expected result into a queue when the word is accepted; an independent
//   monitor pops and compares on every output transfer.
module tb_extend_pipe;

  localparam int NB_DATA = 32;
  localparam int NB_WORD = 16;
  localparam int NB_MODE = 3;

  typedef struct packed {
    logic [NB_DATA-1:0] data;
    logic               err;
  } exp_t;

  logic               clock = 1'b0;
  logic               reset;
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [NB_MODE-1:0] in_mode;
  logic [NB_WORD-1:0] in_data;
  logic               out_valid;
  logic               out_ready;
  logic [NB_DATA-1:0] out_data;
  logic               out_err;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  extend_pipe #(
    .NB_DATA(NB_DATA),
    .NB_WORD(NB_WORD),
    .NB_MODE(NB_MODE)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_mode  (in_mode),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_err  (out_err)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Offers one word for one cycle; the expected result is queued only if
  // the handshake actually happens.
  task automatic applyStimulus(input logic [NB_MODE-1:0] mode,
                               input logic [NB_WORD-1:0] data,
                               input logic [NB_DATA-1:0] exp_data,
                               input logic exp_err, output logic accepted);
    in_valid = 1'b1;
    in_mode  = mode;
    in_data  = data;
    @(negedge clock);
    accepted = in_ready;
    if (accepted) exp_q.push_back({exp_data, exp_err});
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  // Monitor: every output transfer must match the oldest queued result.
  always @(negedge clock) begin
    exp_t e;
    if (!reset && !flush && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_output: got 0x%08h, expected no output", out_data);
      end else begin
        e = exp_q.pop_front();
        checkOutput("out_data", out_data, e.data);
        checkOutput("out_err", 32'(out_err), 32'(e.err));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  localparam int NVEC = 10;
  logic [NB_MODE-1:0] vec_mode [NVEC] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4,
                                          3'd5, 3'd6, 3'd7, 3'd0, 3'd5};
  logic [NB_WORD-1:0] vec_data [NVEC] = '{16'h8001, 16'h8001, 16'h1234,
                                          16'h0080, 16'h00FF, 16'hFFFF,
                                          16'h7FFF, 16'h1234, 16'h7FFF,
                                          16'h4001};
  logic [NB_DATA-1:0] vec_exp  [NVEC] = '{32'hFFFF8001, 32'h00008001,
                                          32'h12340000, 32'hFFFFFF80,
                                          32'h000000FF, 32'hFFFFFFFC,
                                          32'h00000000, 32'h00000000,
                                          32'h00007FFF, 32'h00010004};
  logic               vec_err  [NVEC] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                          1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    logic acc;
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_mode   = '0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    $display("[TB] reset state");
    @(negedge clock);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_out_data", out_data, 32'd0);
    checkOutput("rst_out_err", 32'(out_err), 32'd0);
    @(posedge clock);
    #1;

    $display("[TB] extension modes");
    out_ready = 1'b1;
    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vec_mode[i], vec_data[i], vec_exp[i], vec_err[i], acc);
      checkOutput("mode_accept", 32'(acc), 32'd1);
      @(negedge clock);
      checkOutput("mode_latency", 32'(out_valid), 32'd1);
      @(posedge clock);
      #1;
    end

    $display("[TB] backpressure");
    out_ready = 1'b0;
    applyStimulus(3'd0, 16'h0001, 32'h00000001, 1'b0, acc);
    checkOutput("bp_a_accept", 32'(acc), 32'd1);
    applyStimulus(3'd0, 16'h0002, 32'h00000002, 1'b0, acc);
    checkOutput("bp_b_accept", 32'(acc), 32'd1);
    applyStimulus(3'd0, 16'h0003, 32'h00000003, 1'b0, acc);
    checkOutput("bp_c_refused", 32'(acc), 32'd0);
    @(negedge clock);
    checkOutput("bp_hold_valid", 32'(out_valid), 32'd1);
    checkOutput("bp_hold_data", out_data, 32'h00000001);
    checkOutput("bp_in_ready_low", 32'(in_ready), 32'd0);
    @(posedge clock);
    #1;
    out_ready = 1'b1;
    fork
      begin
        logic acc_c;
        acc_c = 1'b0;
        for (int k = 0; k < 6 && !acc_c; k++)
          applyStimulus(3'd0, 16'h0003, 32'h00000003, 1'b0, acc_c);
        checkOutput("bp_c_accepted", 32'(acc_c), 32'd1);
      end
      begin
        repeat (3) begin
          @(negedge clock);
          checkOutput("bp_consecutive", 32'(out_valid), 32'd1);
        end
      end
    join
    @(posedge clock);
    #1;

    $display("[TB] streaming");
    fork
      begin
        logic               acc_s;
        logic [NB_WORD-1:0] d;
        logic [NB_DATA-1:0] e;
        for (int i = 0; i < 16; i++) begin
          d = (16'(i) << 12) | 16'(i);
          e = (i % 2 == 0) ? {{16{d[15]}}, d} : {16'h0000, d};
          applyStimulus((i % 2 == 0) ? 3'd0 : 3'd1, d, e, 1'b0, acc_s);
          checkOutput("stream_in_ready", 32'(acc_s), 32'd1);
        end
      end
      begin
        @(negedge clock);
        repeat (16) begin
          @(negedge clock);
          checkOutput("stream_out_valid", 32'(out_valid), 32'd1);
        end
      end
    join
    @(posedge clock);
    #1;

    $display("[TB] flush");
    out_ready = 1'b0;
    applyStimulus(3'd0, 16'h0011, 32'h00000011, 1'b0, acc);
    applyStimulus(3'd0, 16'h0022, 32'h00000022, 1'b0, acc);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'h0033;
    exp_q.delete();
    @(posedge clock);
    #1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clock);
    checkOutput("flush_out_valid", 32'(out_valid), 32'd0);
    checkOutput("flush_in_ready", 32'(in_ready), 32'd1);
    @(posedge clock);
    #1;
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'h0044;
    @(posedge clock);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    repeat (3) begin
      @(negedge clock);
      checkOutput("flush_drop_input", 32'(out_valid), 32'd0);
    end
    @(posedge clock);
    #1;

    $display("[TB] reset mid-stream");
    out_ready = 1'b0;
    applyStimulus(3'd6, 16'h0055, 32'h00000000, 1'b1, acc);
    applyStimulus(3'd0, 16'h0066, 32'h00000066, 1'b0, acc);
    reset     = 1'b1;
    out_ready = 1'b1;
    exp_q.delete();
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    checkOutput("mid_rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("mid_rst_out_data", out_data, 32'd0);
    checkOutput("mid_rst_out_err", 32'(out_err), 32'd0);
    checkOutput("mid_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clock);
    #1;
    applyStimulus(3'd2, 16'hABCD, 32'hABCD0000, 1'b0, acc);
    checkOutput("post_rst_accept", 32'(acc), 32'd1);
    @(negedge clock);
    checkOutput("post_rst_latency", 32'(out_valid), 32'd1);

    repeat (3) @(posedge clock);
    #1;
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
